// File: rtl/nic8_bus_pkg.sv
// nic8_bus_pkg: shared encodings, FSM states and request type for the nic8 bus-transfer controller
package nic8_bus_pkg;
  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_X    = 2'd1;
  localparam logic [1:0] SRC_IMM  = 2'd2;
  localparam logic [1:0] SRC_RSVD = 2'd3;
  localparam int DST_A = 3;
  localparam int DST_B = 2;
  localparam int DST_X = 1;
  localparam int DST_Q = 0;
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, RELEASE} state_t;
  typedef struct packed {
    logic [1:0] src;
    logic [3:0] dst;
    logic [7:0] imm;
  } xfer_req_t;
endpackage

// File: rtl/xfer_fifo.sv
// xfer_fifo: synchronous request FIFO, power-of-2 DEPTH; push when full and pop when empty are ignored
module xfer_fifo
  import nic8_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  xfer_req_t              din,
  output xfer_req_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  xfer_req_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: nic8 bus-transfer initiator sequencing GPR assert-bar/load strobes and immediate drive on dbus
// Define BUS_XFER_COUNT_EN to add the 16-bit xfer_count output counting LATCH cycles.
module bus_xfer_ctrl
  import nic8_bus_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_src,
  input  logic [3:0]  req_dst,
  input  logic [7:0]  req_imm,
  inout  wire  [7:0]  dbus,
  output logic        assert_bar_a,
  output logic        assert_bar_x,
  output logic        load_a,
  output logic        load_b,
  output logic        load_x,
  output logic        load_q,
  output logic        busy,
  output logic        err
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [15:0] xfer_count
`endif
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_t state, state_nx;
  xfer_req_t cur, head, din;
  logic [CW-1:0] cnt;
  logic [$clog2(DEPTH):0] count;
  logic [3:0] ld;
  logic full, empty, accept, push, pop, en, drive_imm;
  assign accept = req_valid && req_ready;
  assign push = accept && req_src != SRC_RSVD && req_dst != 4'd0;
  assign pop = (state == IDLE || state == RELEASE) && !empty;
  assign din = {req_src, req_dst, req_imm};
  assign req_ready = !full;
  assign busy = count != '0 || state != IDLE;
  assign dbus = drive_imm ? cur.imm : 8'hzz;
  xfer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == DRIVE ? cnt + 1'b1 : '0;
      if (accept && req_src == SRC_RSVD) err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (pop) cur <= head;
  // loads are gated by reset so an abandoned LATCH never reaches the GPRs
  always_comb begin
    state_nx = state;
    en = 1'b0;
    ld = 4'd0;
    state_nx = state == IDLE  ? (empty ? IDLE : DRIVE) :
               state == DRIVE ? (cnt == CW'(SETTLE - 1) ? LATCH : DRIVE) :
               state == LATCH ? RELEASE : (empty ? IDLE : DRIVE);
    en = state == DRIVE || state == LATCH;
    ld = state == LATCH && !reset ? cur.dst : 4'd0;
    assert_bar_a = !(en && cur.src == SRC_A);
    assert_bar_x = !(en && cur.src == SRC_X);
    drive_imm = en && cur.src == SRC_IMM;
    load_a = ld[DST_A];
    load_b = ld[DST_B];
    load_x = ld[DST_X];
    load_q = ld[DST_Q];
  end
`ifdef BUS_XFER_COUNT_EN
  always_ff @(posedge clk)
    xfer_count <= reset ? 16'd0 : xfer_count + 16'(state == LATCH);
`endif
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: scoreboard bench for bus_xfer_ctrl with a GPR bank model on dbus
module tb_bus_xfer_ctrl;
  import nic8_bus_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [1:0] src;
    logic [3:0] dst;
    logic [7:0] val;
  } exp_t;
  logic clk = 0, reset = 1, req_valid = 0;
  logic [1:0] req_src = 0;
  logic [3:0] req_dst = 0;
  logic [7:0] req_imm = 0;
  wire [7:0] dbus;
  logic req_ready, assert_bar_a, assert_bar_x, load_a, load_b, load_x, load_q, busy, err;
  logic [3:0] loads;
  logic [7:0] ga = 0, gb = 0, gx = 0, gq = 0, ra = 0, rb = 0, rx = 0, rq = 0;
  logic prev_load = 0, saw_full = 0;
  exp_t prev_e;
  exp_t sbq[$];
  int checks = 0, errors = 0, lat_cnt = 0;
`ifdef BUS_XFER_COUNT_EN
  logic [15:0] xfer_count;
`endif
  bus_xfer_ctrl #(.DEPTH(DEPTH), .SETTLE(1)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src(req_src),
    .req_dst(req_dst),
    .req_imm(req_imm),
    .dbus(dbus),
    .assert_bar_a(assert_bar_a),
    .assert_bar_x(assert_bar_x),
    .load_a(load_a),
    .load_b(load_b),
    .load_x(load_x),
    .load_q(load_q),
    .busy(busy),
    .err(err)
`ifdef BUS_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );
  assign loads = {load_a, load_b, load_x, load_q};
  assign dbus = !assert_bar_a ? ga : !assert_bar_x ? gx : 8'hzz;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load_a) ga <= dbus;
    if (load_b) gb <= dbus;
    if (load_x) gx <= dbus;
    if (load_q) gq <= dbus;
  end
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_load = 0;
      lat_cnt = 0;
    end else begin
      checks++;
      if (!assert_bar_a && !assert_bar_x) begin
        errors++;
        $display("FAIL src_exclusive: assert_bar_a=%b assert_bar_x=%b, required not both low", assert_bar_a, assert_bar_x);
      end
      if (prev_load) begin
        checks++;
        if (!assert_bar_a || !assert_bar_x || loads != 0 || (prev_e.src == SRC_IMM && dbus === prev_e.val)) begin
          errors++;
          $display("FAIL release_gap: bars=%b%b loads=%b dbus=%h, required bars 11, loads 0, bus released", assert_bar_a, assert_bar_x, loads, dbus);
        end
      end
      prev_load = 0;
      if (loads != 0) begin
        lat_cnt++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: loads=%b with no transfer expected", loads);
        end else begin
          e = sbq.pop_front();
          prev_e = e;
          prev_load = 1;
          if (loads !== e.dst || dbus !== e.val || assert_bar_a !== (e.src != SRC_A) || assert_bar_x !== (e.src != SRC_X)) begin
            errors++;
            $display("FAIL latch: loads=%b dbus=%h bars=%b%b, required loads=%b dbus=%h src=%0d", loads, dbus, assert_bar_a, assert_bar_x, e.dst, e.val, e.src);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // mode 0: no transfer expected; 1: transfer expected, GPRs not updated; 2: transfer updates GPRs
  task automatic send(input logic [1:0] s, input logic [3:0] d, input logic [7:0] i, input int mode);
    int t = 0;
    exp_t e;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL send_ready: req_ready=%b required 1 within 50 cycles", req_ready);
    end
    req_valid = 1;
    req_src = s;
    req_dst = d;
    req_imm = i;
    @(negedge clk);
    req_valid = 0;
    if (mode != 0) begin
      e.src = s;
      e.dst = d;
      e.val = s == SRC_A ? ra : s == SRC_X ? rx : i;
      sbq.push_back(e);
      if (mode == 2) begin
        if (d[DST_A]) ra = e.val;
        if (d[DST_B]) rb = e.val;
        if (d[DST_X]) rx = e.val;
        if (d[DST_Q]) rq = e.val;
      end
    end
  endtask
  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0 within 100 cycles", name, busy);
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (assert_bar_a !== 1 || assert_bar_x !== 1 || loads !== 0) begin
      errors++;
      $display("FAIL reset_strobes: bars=%b%b loads=%b, required 11 and 0000", assert_bar_a, assert_bar_x, loads);
    end
    checks++;
    if (req_ready !== 1 || busy !== 0 || err !== 0) begin
      errors++;
      $display("FAIL reset_status: ready=%b busy=%b err=%b, required 1 0 0", req_ready, busy, err);
    end
    reset = 0;
  endtask
  task automatic test_basic();
    send(SRC_IMM, 4'b1000, 8'h5A, 2);
    wait_idle("basic_pre");
    send(SRC_A, 4'b0100, 8'h00, 2);
    checks++;
    if (assert_bar_a !== 1 || busy !== 1) begin
      errors++;
      $display("FAIL basic_c0: bar_a=%b busy=%b, required 1 1", assert_bar_a, busy);
    end
    @(negedge clk);
    checks++;
    if (assert_bar_a !== 0 || load_b !== 0 || dbus !== 8'h5A) begin
      errors++;
      $display("FAIL basic_c1: bar_a=%b load_b=%b dbus=%h, required 0 0 5a", assert_bar_a, load_b, dbus);
    end
    @(negedge clk);
    checks++;
    if (assert_bar_a !== 0 || loads !== 4'b0100) begin
      errors++;
      $display("FAIL basic_c2: bar_a=%b loads=%b, required 0 0100", assert_bar_a, loads);
    end
    @(negedge clk);
    checks++;
    if (assert_bar_a !== 1 || loads !== 0 || gb !== 8'h5A || busy !== 1) begin
      errors++;
      $display("FAIL basic_c3: bar_a=%b loads=%b B=%h busy=%b, required 1 0000 5a 1", assert_bar_a, loads, gb, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL basic_c4: busy=%b required 0", busy);
    end
  endtask
  task automatic test_imm_multi();
    send(SRC_IMM, 4'b1011, 8'hC3, 2);
    @(negedge clk);
    checks++;
    if (dbus !== 8'hC3 || assert_bar_a !== 1 || assert_bar_x !== 1) begin
      errors++;
      $display("FAIL imm_drive: dbus=%h bars=%b%b, required c3 11", dbus, assert_bar_a, assert_bar_x);
    end
    wait_idle("imm");
    checks++;
    if (ga !== 8'hC3 || gx !== 8'hC3 || gq !== 8'hC3 || gb !== 8'h5A) begin
      errors++;
      $display("FAIL imm_regs: A=%h B=%h X=%h Q=%h, required c3 5a c3 c3", ga, gb, gx, gq);
    end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (!req_ready) saw_full = 1;
      send(SRC_IMM, 4'(1 << (k % 4)), 8'h10 + 8'(k), 2);
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL b2b_ready: req_ready never dropped, required low when FIFO full");
    end
    wait_idle("b2b");
    checks++;
    if (ga !== ra || gb !== rb || gx !== rx || gq !== rq) begin
      errors++;
      $display("FAIL b2b_regs: A=%h B=%h X=%h Q=%h, required %h %h %h %h", ga, gb, gx, gq, ra, rb, rx, rq);
    end
  endtask
  task automatic test_filter();
    send(SRC_RSVD, 4'b1111, 8'hEE, 0);
    checks++;
    if (err !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL rsvd_err: err=%b busy=%b, required 1 0", err, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1 || busy !== 0 || !assert_bar_a || !assert_bar_x) begin
      errors++;
      $display("FAIL rsvd_sticky: err=%b busy=%b bars=%b%b, required 1 0 11", err, busy, assert_bar_a, assert_bar_x);
    end
    send(SRC_X, 4'b0000, 8'h00, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1 || busy !== 0 || !assert_bar_x) begin
      errors++;
      $display("FAIL dst0_drop: err=%b busy=%b bar_x=%b, required 1 0 1", err, busy, assert_bar_x);
    end
  endtask
  task automatic test_reset_mid();
    int t = 0;
    send(SRC_IMM, 4'b0010, 8'h77, 2);
    wait_idle("rst_pre");
    send(SRC_X, 4'b0001, 8'h00, 1);
    send(SRC_IMM, 4'b0100, 8'h11, 0);
    send(SRC_IMM, 4'b1000, 8'h22, 0);
    while (!load_q && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!load_q) begin
      errors++;
      $display("FAIL rst_latch: load_q=%b, required 1 within 20 cycles", load_q);
    end
    #1 reset = 1;
    @(negedge clk);
    checks++;
    if (!assert_bar_a || !assert_bar_x || loads != 0 || busy !== 0 || req_ready !== 1 || err !== 0) begin
      errors++;
      $display("FAIL rst_mid: bars=%b%b loads=%b busy=%b ready=%b err=%b, required 11 0000 0 1 0", assert_bar_a, assert_bar_x, loads, busy, req_ready, err);
    end
    reset = 0;
    repeat (15) @(negedge clk);
    checks++;
    if (gq !== rq || gb !== rb || ga !== ra || busy !== 0) begin
      errors++;
      $display("FAIL rst_flush: A=%h B=%h Q=%h busy=%b, required %h %h %h 0", ga, gb, gq, busy, ra, rb, rq);
    end
  endtask
`ifdef BUS_XFER_COUNT_EN
  task automatic test_count();
    for (int k = 0; k < 3; k++) send(SRC_IMM, 4'b0100, 8'h30 + 8'(k), 2);
    wait_idle("count");
    checks++;
    if (xfer_count !== 16'd3 || lat_cnt != 3) begin
      errors++;
      $display("FAIL xfer_count: got %0d (latches seen %0d), required 3", xfer_count, lat_cnt);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_imm_multi();
    test_back_to_back();
    test_filter();
    test_reset_mid();
`ifdef BUS_XFER_COUNT_EN
    test_count();
`endif
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected transfers never latched, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Bus-transfer initiator for the nic8 data bus. It accepts queued register-to-register transfer requests and sequences the per-register assert-bar and load strobes that the GPR bank responds to. It also drives immediate bytes onto `dbus` itself. Only one driver is ever enabled on `dbus`, and a dead cycle separates consecutive drivers.

## Interface
Parameters:
- `DEPTH`, 4, request FIFO depth; power of 2, ≥2
- `SETTLE`, 1, cycles `dbus` is driven before the load cycle; ≥1

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  FIFO can accept
- `req_src`  in  2  source: 0=A, 1=X, 2=IMM, 3=reserved
- `req_dst`  in  4  load mask {A,B,X,Q}, bit3=A … bit0=Q
- `req_imm`  in  8  byte driven when src=IMM
- `dbus`  inout  8  shared data bus; driven only for IMM, else `'z`
- `assert_bar_a`, `assert_bar_x`  out  1  active-low source enables to GPR bank
- `load_a`, `load_b`, `load_x`, `load_q`  out  1  destination load strobes
- `busy`  out  1  FIFO non-empty or state≠IDLE
- `err`  out  1  sticky; set on reserved source

## Operation
- Handshake: accept when `req_valid && req_ready` at a rising edge. `req_ready = (count < DEPTH)`; no same-cycle pass-through when full.
- Push-time filtering:
  - `req_src==3`: request dropped, `err` set. `err` clears only on reset.
  - `req_dst==0` with legal source: request dropped silently, no bus activity.
  - Otherwise the request is pushed.
- FSM states:
  - IDLE: all strobes inactive. Goes to DRIVE when the FIFO is non-empty; the head is popped into a working register on that edge.
  - DRIVE: source enable active; an `SETTLE`-cycle counter runs. Goes to LATCH when the count expires.
  - LATCH: source enable stays active; loads from `req_dst` are high for exactly 1 cycle. The GPRs capture at the edge that ends LATCH. Always goes to RELEASE.
  - RELEASE: all enables and loads inactive, `dbus='z`. Goes to DRIVE (popping the FIFO) if non-empty, else IDLE.
- Source decode: A → `assert_bar_a=0`; X → `assert_bar_x=0`; IMM → controller drives `req_imm` on `dbus`. At most one of these is active in any cycle.
- Multi-bit `req_dst` loads all selected registers in the same LATCH cycle. A source included in its own destination (e.g. A→A) is legal.
- Simultaneous push and pop in the same cycle: count is unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `assert_bar_a=assert_bar_x=1`; all loads 0; `dbus='z`.
  - `req_ready=1`, `busy=0`, `err=0`; state IDLE; FIFO empty.
- Reset mid-transfer: strobes go inactive at the next edge, the in-flight transfer is abandoned (no load), and the FIFO is flushed.
- Latency: request accepted at edge 0 with the controller idle → DRIVE from edge 1, LATCH from edge 1+SETTLE, destination updated at edge 2+SETTLE.
- Throughput: one transfer per SETTLE+2 cycles back-to-back.
- Loads are never active in a cycle where no source is enabled.

## Configuration
- `BUS_XFER_COUNT_EN` defined:
  - Adds output `xfer_count` [15:0].
  - Increments by 1 on every LATCH cycle and wraps at 16'hFFFF→0.
  - Resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `nic8_bus_pkg`:
  - source encodings (`SRC_A`, `SRC_X`, `SRC_IMM`, `SRC_RSVD`)
  - destination mask bit indices
  - FSM state enum {IDLE, DRIVE, LATCH, RELEASE}
  - request struct {src, dst, imm}
- Sub-module `xfer_fifo`: synchronous FIFO of request structs, parameter `DEPTH`, with push/pop/count/full/empty. The top level holds the FSM, settle counter, strobe decode and `dbus` tristate.

## Test plan
- A=8'h5A in the GPR model; request src=A, dst=B with SETTLE=1 → `assert_bar_a` low for cycles 1–2, `load_b` high in cycle 2 only, B=8'h5A after edge 3, `busy` low from edge 4.
- Request IMM 8'hC3 with dst=4'b1011 → `dbus`=8'hC3 during DRIVE and LATCH; A, X and Q all load 8'hC3 simultaneously; B unchanged.
- Push DEPTH+1 requests back-to-back with the controller stalled in its first transfer → `req_ready` drops when count=DEPTH; all queued transfers execute in order, each separated by one RELEASE cycle with `dbus='z` and both assert-bars high.
- `req_src`=3 → `err`=1 and stays set; no strobes; FIFO count unchanged. `req_dst`=0 with src=X → no strobes, `err` unchanged.
- Assert `reset` during LATCH of an X→Q transfer with 2 requests queued → next cycle all strobes inactive, `busy=0`, Q unchanged, queued requests never execute.
- With `BUS_XFER_COUNT_EN`: 3 completed transfers → `xfer_count`=3; preload 16'hFFFF via forced state, one transfer → 0.
